// File: rtl/sha3_perm_arbiter.sv
// Round-robin arbiter lending one Keccak-f[1600] core to N_REQ message sources.
// A grant covers a whole message: core clear, every block, and the final hash.
//
// state     | meaning
// IDLE      | no owner, arbitrating among REQ_VALID
// CLEAR     | one-cycle CORE_CLR for the new owner
// FEED      | waiting to hand the owner's next block to the core
// ABSORB    | core permuting a non-final block (watchdog running)
// WAIT_HASH | core running the final permutation (watchdog running)
module sha3_perm_arbiter #(
    parameter int R_BLOCK_SIZE = 1152,
    parameter int N_REQ        = 2,
    parameter int TIMEOUT      = 64,
    localparam int GW          = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int WW          = $clog2(TIMEOUT + 1)
) (
    input  logic                            CLK,
    input  logic                            A_RST,
    input  logic                            CE,
    input  logic [N_REQ-1:0]                REQ_VALID,
    input  logic [N_REQ-1:0]                REQ_LAST,
    input  logic [N_REQ*R_BLOCK_SIZE-1:0]   REQ_DATA,
    output logic [N_REQ-1:0]                REQ_READY,
    output logic [R_BLOCK_SIZE-1:0]         CORE_IN,
    output logic                            CORE_VALID,
    output logic                            CORE_LAST,
    output logic                            CORE_CLR,
    input  logic                            CORE_READY,
    input  logic                            CORE_HASH_VALID,
    output logic [GW-1:0]                   GRANT_ID,
    output logic                            BUSY,
    output logic [N_REQ-1:0]                DONE,
    output logic                            ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_ABSORB,
        S_WAIT_HASH
    } state_t;

    state_t           state;
    logic [GW-1:0]    grant_id;
    logic [GW-1:0]    last_grant;
    logic [WW-1:0]    wdog;
    logic             seen_fall;
    logic [N_REQ-1:0] done_q;
    logic             err_q;

    logic [GW-1:0]    pick;
    logic             pick_found;
    logic             accept;
    logic             wd_expired;
    logic [N_REQ-1:0] grant_onehot;

    // Search starts just after the previous winner so every source gets a turn.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!pick_found && REQ_VALID[(int'(last_grant) + i) % N_REQ]) begin
                pick       = GW'((int'(last_grant) + i) % N_REQ);
                pick_found = 1'b1;
            end
        end
    end

    assign grant_onehot = N_REQ'(1) << grant_id;
    assign accept       = (state == S_FEED) && CE && CORE_READY && REQ_VALID[grant_id];
    assign wd_expired   = (wdog == WW'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge A_RST) begin
        if (A_RST) begin
            state      <= S_IDLE;
            grant_id   <= '0;
            last_grant <= GW'(N_REQ - 1);
            wdog       <= '0;
            seen_fall  <= 1'b0;
            done_q     <= '0;
            err_q      <= 1'b0;
        end else if (CE) begin
            done_q <= '0;
            err_q  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_id   <= pick;
                        last_grant <= pick;
                        state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    state <= S_FEED;
                end
                S_FEED: begin
                    if (accept) begin
                        wdog      <= '0;
                        seen_fall <= 1'b0;
                        state     <= REQ_LAST[grant_id] ? S_WAIT_HASH : S_ABSORB;
                    end
                end
                S_ABSORB: begin
                    // The core drops READY the cycle after a block; only a rise after that fall
                    // means it is ready again. A rise beats a simultaneous timeout.
                    if (seen_fall && CORE_READY) begin
                        state <= S_FEED;
                    end else if (wd_expired) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + WW'(1);
                        if (!CORE_READY) begin
                            seen_fall <= 1'b1;
                        end
                    end
                end
                S_WAIT_HASH: begin
                    if (CORE_HASH_VALID) begin
                        done_q <= grant_onehot;
                        state  <= S_IDLE;
                    end else if (wd_expired) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are masked by CE; the registered DONE/ERR hold so they reappear once CE returns.
    assign REQ_READY  = accept ? grant_onehot : '0;
    assign CORE_VALID = accept;
    assign CORE_LAST  = accept && REQ_LAST[grant_id];
    assign CORE_CLR   = (state == S_CLEAR) && CE;
    assign CORE_IN    = (state == S_FEED) ? REQ_DATA[int'(grant_id)*R_BLOCK_SIZE +: R_BLOCK_SIZE]
                                          : '0;
    assign GRANT_ID   = grant_id;
    assign BUSY       = (state != S_IDLE);
    assign DONE       = done_q & {N_REQ{CE}};
    assign ERR        = err_q & CE;

endmodule

// File: tb/tb_sha3_perm_arbiter.sv
// Scoreboard bench for sha3_perm_arbiter: blocks and DONE/ERR expectations are queued
// as stimulus is driven and retired by a monitor when the DUT produces them.
module tb_sha3_perm_arbiter;

    localparam int RB = 1152;
    localparam int NR = 2;
    localparam int TO = 64;

    logic              CLK;
    logic              A_RST;
    logic              CE;
    logic [NR-1:0]     REQ_VALID;
    logic [NR-1:0]     REQ_LAST;
    logic [NR*RB-1:0]  REQ_DATA;
    logic [NR-1:0]     REQ_READY;
    logic [RB-1:0]     CORE_IN;
    logic              CORE_VALID;
    logic              CORE_LAST;
    logic              CORE_CLR;
    logic              CORE_READY;
    logic              CORE_HASH_VALID;
    logic [0:0]        GRANT_ID;
    logic              BUSY;
    logic [NR-1:0]     DONE;
    logic              ERR;

    sha3_perm_arbiter #(.R_BLOCK_SIZE(RB), .N_REQ(NR), .TIMEOUT(TO)) dut (
        .CLK(CLK), .A_RST(A_RST), .CE(CE),
        .REQ_VALID(REQ_VALID), .REQ_LAST(REQ_LAST), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
        .CORE_IN(CORE_IN), .CORE_VALID(CORE_VALID), .CORE_LAST(CORE_LAST), .CORE_CLR(CORE_CLR),
        .CORE_READY(CORE_READY), .CORE_HASH_VALID(CORE_HASH_VALID),
        .GRANT_ID(GRANT_ID), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          id;
        logic [63:0] f;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   exp_done[$];
    int   err_expect = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   n_core = 0;
    int   clr_cnt = 0;
    int   last_clr_cyc = 0;
    int   last_acc_cyc = 0;
    int   err_cyc = 0;
    bit   hash_en = 1'b1;
    bit   core_lb;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] fold(input logic [RB-1:0] d);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < RB/64; i++) s = s + d[i*64 +: 64] * 64'(2*i + 1);
        return s;
    endfunction

    function automatic logic [RB-1:0] rand_blk();
        logic [RB-1:0] d;
        for (int i = 0; i < RB/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Core model: busy for three cycles after each block, then hash pulse after a last block.
    initial begin
        CORE_READY      = 1'b1;
        CORE_HASH_VALID = 1'b0;
        forever begin
            @(negedge CLK);
            if (CORE_VALID) begin
                core_lb = CORE_LAST;
                @(posedge CLK); #1 CORE_READY = 1'b0;
                repeat (3) @(posedge CLK);
                #1 CORE_READY = 1'b1;
                if (core_lb && hash_en) begin
                    CORE_HASH_VALID = 1'b1;
                    @(posedge CLK); #1 CORE_HASH_VALID = 1'b0;
                end
            end
        end
    end

    // Monitor retires scoreboard entries mid-cycle.
    always @(negedge CLK) begin
        if (CORE_CLR) begin
            clr_cnt++;
            last_clr_cyc = cyc;
        end
        if (CORE_VALID) begin
            n_core++;
            last_acc_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("core_unexp_q", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("core_data", fold(CORE_IN), e.f);
                chk("core_last", CORE_LAST, e.last);
                chk("grant", GRANT_ID, e.id);
                chk("req_ready", REQ_READY, 64'(1) << e.id);
            end
        end
        if (DONE != '0) begin
            if (exp_done.size() == 0) begin
                chk("done_unexp", DONE, 0);
            end else begin
                int id;
                id = exp_done.pop_front();
                chk("done", DONE, 64'(1) << id);
            end
        end
        if (ERR) begin
            if (err_expect > 0) begin
                err_expect--;
                err_cyc = cyc;
                chk("err_done", DONE, 0);
            end else begin
                chk("err_unexp", ERR, 0);
            end
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic reset_dut();
        A_RST = 1'b1;
        tick();
        A_RST = 1'b0;
    endtask

    task automatic send_block(input int id, input bit last, input bit want_done);
        logic [RB-1:0] d;
        int n;
        d = rand_blk();
        REQ_DATA[id*RB +: RB] = d;
        REQ_LAST[id]  = last;
        REQ_VALID[id] = 1'b1;
        exp_q.push_back('{id, fold(d), last});
        if (last && want_done) exp_done.push_back(id);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!REQ_READY[id] && n < 200);
        if (!REQ_READY[id]) chk("accept_timeout", REQ_READY[id], 1);
        tick();
        REQ_VALID[id] = 1'b0;
        REQ_LAST[id]  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_done.size() > 0 || err_expect > 0) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("done_wait", exp_done.size(), 0);
        chk("err_wait", err_expect, 0);
        tick();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk(tag, {BUSY, CORE_VALID, CORE_LAST, CORE_CLR, ERR, REQ_READY, DONE, GRANT_ID}, 0);
        chk({tag, "_core_in"}, fold(CORE_IN), 0);
    endtask

    initial begin
        int t0, c0, n0, gap, s0, s1, n;
        bit seen_busy;
        logic [NR-1:0] acc;
        logic [RB-1:0] rr_blk [NR][2];

        CE = 1'b1; A_RST = 1'b1;
        REQ_VALID = '0; REQ_LAST = '0; REQ_DATA = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_outputs_zero("reset_state");
        tick();
        A_RST = 1'b0;
        tick();

        // Single three-block message from requester 0.
        c0 = clr_cnt; n0 = n_core; t0 = cyc;
        send_block(0, 1'b0, 1'b0);
        chk("first_accept_cyc", last_acc_cyc - t0, 2);
        chk("clr_cyc", last_clr_cyc - t0, 1);
        send_block(0, 1'b0, 1'b0);
        send_block(0, 1'b1, 1'b1);
        wait_done();
        chk("clr_count", clr_cnt - c0, 1);
        chk("block_count", n_core - n0, 3);

        // Round robin with both requesters holding one-block messages.
        reset_dut();
        for (int i = 0; i < NR; i++)
            for (int s = 0; s < 2; s++) rr_blk[i][s] = rand_blk();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < NR; i++) begin
                exp_q.push_back('{i, fold(rr_blk[i][s]), 1'b1});
                exp_done.push_back(i);
            end
        REQ_DATA[0 +: RB]  = rr_blk[0][0];
        REQ_DATA[RB +: RB] = rr_blk[1][0];
        REQ_LAST = '1; REQ_VALID = '1;
        s0 = 0; s1 = 0; gap = 0; seen_busy = 1'b0; n = 0;
        while (!(s0 == 2 && s1 == 2 && exp_done.size() == 0) && n < 600) begin
            @(negedge CLK);
            n++;
            if (BUSY) begin
                if (seen_busy && gap > 0) chk("busy_gap", gap, 1);
                gap = 0;
                seen_busy = 1'b1;
            end else begin
                gap++;
            end
            acc = REQ_READY;
            tick();
            if (acc[0]) begin
                s0++;
                if (s0 == 2) REQ_VALID[0] = 1'b0; else REQ_DATA[0 +: RB] = rr_blk[0][s0];
            end
            if (acc[1]) begin
                s1++;
                if (s1 == 2) REQ_VALID[1] = 1'b0; else REQ_DATA[RB +: RB] = rr_blk[1][s1];
            end
        end
        chk("rr_done_left", exp_done.size(), 0);
        REQ_LAST = '0;
        tick();

        // Lock hold: owner pauses mid-message while requester 1 waits.
        reset_dut();
        send_block(0, 1'b0, 1'b0);
        REQ_VALID[1] = 1'b1;
        REQ_DATA[RB +: RB] = rand_blk();
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("lock_grant", GRANT_ID, 0);
            chk("lock_rdy1", REQ_READY[1], 0);
            tick();
        end
        REQ_VALID[1] = 1'b0;
        send_block(0, 1'b1, 1'b1);
        wait_done();

        // Watchdog: final hash never arrives.
        hash_en = 1'b0;
        err_expect = 1;
        send_block(1, 1'b1, 1'b0);
        wait_done();
        chk("wd_delay", err_cyc - last_acc_cyc, TO + 1);
        @(negedge CLK);
        chk("wd_idle", BUSY, 0);
        tick();
        hash_en = 1'b1;
        repeat (5) tick();

        // CE gating while the block is presented in FEED.
        begin
            logic [RB-1:0] d;
            d = rand_blk();
            REQ_DATA[0 +: RB] = d; REQ_LAST[0] = 1'b1; REQ_VALID[0] = 1'b1;
            exp_q.push_back('{0, fold(d), 1'b1});
            exp_done.push_back(0);
            tick();
            @(negedge CLK);
            chk("ce_clr", CORE_CLR, 1);
            tick();
            CE = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge CLK);
                chk("ce_valid", CORE_VALID, 0);
                chk("ce_ready", REQ_READY, 0);
                chk("ce_busy", BUSY, 1);
                tick();
            end
            CE = 1'b1;
            @(negedge CLK);
            chk("ce_accept", CORE_VALID, 1);
            tick();
            REQ_VALID[0] = 1'b0; REQ_LAST[0] = 1'b0;
            wait_done();
        end

        // Async reset in ABSORB, then requester 0 wins despite 1 being last granted.
        send_block(1, 1'b0, 1'b0);
        #2 A_RST = 1'b1;
        #1 chk_outputs_zero("async_reset");
        tick();
        A_RST = 1'b0;
        REQ_VALID[1] = 1'b1; REQ_LAST[1] = 1'b1; REQ_DATA[RB +: RB] = rand_blk();
        send_block(0, 1'b1, 1'b1);
        chk("post_reset_grant", GRANT_ID, 0);
        REQ_VALID[1] = 1'b0; REQ_LAST[1] = 1'b0;
        wait_done();

        repeat (10) tick();
        chk("exp_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sha3_perm_arbiter.md
Name: sha3_perm_arbiter

Overview:
- Shares one Keccak-f[1600] permutation core between N_REQ independent message sources.
- Grants the core to one requester for a whole message, from the first block through the final permutation. Per-message core state clearing is part of that grant.
- Requesters are chosen round-robin.
- Sits between the padding units and the permutation core. A watchdog recovers from a core that never completes.

Parameters:
- R_BLOCK_SIZE, 1152, rate block width in bits, matching the core.
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT, 64, max cycles in ABSORB/WAIT_HASH without core progress before abort (>= 30).

Ports:
- CLK  in  1  clock.
- A_RST  in  1  reset, asynchronous, active-high.
- CE  in  1  clock enable; FSM, counters and registers advance only when CE=1.
- REQ_VALID  in  N_REQ  requester i presents a block.
- REQ_LAST  in  N_REQ  presented block is the last of its message.
- REQ_DATA  in  N_REQ*R_BLOCK_SIZE  requester i block is bits [i*R_BLOCK_SIZE +: R_BLOCK_SIZE].
- REQ_READY  out  N_REQ  block accepted this cycle (one-hot or zero).
- CORE_IN  out  R_BLOCK_SIZE  block to core, muxed by GRANT_ID.
- CORE_VALID  out  1  core block-valid strobe.
- CORE_LAST  out  1  core last-block flag, qualified by CORE_VALID.
- CORE_CLR  out  1  one-cycle synchronous clear of core state.
- CORE_READY  in  1  core idle and waiting for a new block.
- CORE_HASH_VALID  in  1  core final permutation complete.
- GRANT_ID  out  clog2(N_REQ), min 1  current owner.
- BUSY  out  1  state != IDLE.
- DONE  out  N_REQ  one-cycle pulse to owner when its hash is valid.
- ERR  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset values:
  - state=IDLE, GRANT_ID=0, last_grant=N_REQ-1 so requester 0 has first priority, watchdog=0.
  - All outputs 0; CORE_IN is 0 because it is muxed from a zeroed GRANT_ID only while in FEED, else driven 0.
- Reset mid-message: returns to IDLE at once, no DONE, no ERR. A block being presented is not acknowledged.
- IDLE:
  - If any REQ_VALID, pick the first set bit searching from last_grant+1 with wrap-around.
  - Register GRANT_ID and last_grant, then go to CLEAR.
  - If none is set, stay.
- CLEAR: CORE_CLR=1 for exactly one cycle, then FEED. Grant decision at t, CORE_CLR at t+1, FEED at t+2.
- FEED:
  - Accept when REQ_VALID[g] & CORE_READY & CE. Same cycle: CORE_VALID=1, CORE_LAST=REQ_LAST[g], REQ_READY[g]=1.
  - Accept with LAST=0 goes to ABSORB; accept with LAST=1 goes to WAIT_HASH.
  - The owner deasserting REQ_VALID does not release the lock; FEED waits indefinitely with no timeout.
- ABSORB: wait for CORE_READY to fall and then rise again, then FEED. The fall must be seen because the core is busy the cycle after accepting.
- WAIT_HASH:
  - On CORE_HASH_VALID, pulse DONE[g] for one cycle and go to IDLE.
  - New arbitration can start the cycle after DONE.
- Watchdog:
  - Cleared on entry to ABSORB/WAIT_HASH and incremented each CE cycle while there.
  - On reaching TIMEOUT: pulse ERR, go to IDLE, no DONE.
  - In ABSORB, the rising edge of CORE_READY wins over a timeout in the same cycle.
- Requests from non-owners are ignored (REQ_READY=0) until the owner finishes.
- CE=0: all registered state holds and the strobes CORE_VALID, REQ_READY, CORE_CLR, DONE and ERR are forced to 0. A pending strobe is re-issued when CE returns.
- CORE_HASH_VALID outside WAIT_HASH is ignored.

Test Plan:
- Single message, N_REQ=2: REQ_VALID=01 with LAST=0, then two more blocks with the last one LAST=1 -> one CORE_CLR at t+1, three CORE_VALID with CORE_LAST only on the third, then DONE=01 one cycle after CORE_HASH_VALID.
- Round-robin: REQ_VALID=11 held, each message one block with LAST=1 -> grants 0,1,0,1; BUSY returns to 0 for exactly one cycle between messages.
- Lock hold: requester 0 mid-message drops REQ_VALID for 10 cycles while REQ_VALID[1]=1 -> GRANT_ID stays 0 and REQ_READY[1]=0 throughout; requester 0 resumes and completes.
- Watchdog: after the last block, CORE_HASH_VALID is never asserted, TIMEOUT=64 -> ERR pulses 64 cycles after entering WAIT_HASH, DONE stays 0, state returns to IDLE.
- CE gating: CE=0 for 5 cycles during FEED with the block presented -> no CORE_VALID or REQ_READY during those cycles; acceptance occurs on the first CE=1 cycle.
- Async reset during ABSORB -> all outputs 0 immediately; next grant goes to requester 0 even if 1 was last granted.
